sram_device_responder: RTL
==========================

Name: sram_device_responder

Overview:
- Cycle-based responder for the off-chip 16-bit SRAM bus: the device side of the SRAM_DQ/SRAM_ADDR/SRAM_*_N interface driven by the memory-stage SRAM controller.
- Holds a word array, services byte-masked writes, and returns read data on the shared DQ bus after a programmable latency.
- Flags protocol violations and counts accesses.
- Used in simulation benches and FPGA loopback builds in place of the physical chip; a backdoor port preloads and inspects contents.

Parameters:
- ADDR_W, 10, implemented word-address bits (array depth 2^ADDR_W x 16); legal range 1..18.
- READ_LAT, 0, read latency in clk cycles; 0 = asynchronous read; legal range 0..3.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- SRAM_DQ  inout  16  shared data bus.
- SRAM_ADDR  in  18  word address.
- SRAM_UB_N  in  1  high-byte lane enable, active low.
- SRAM_LB_N  in  1  low-byte lane enable, active low.
- SRAM_WE_N  in  1  write enable, active low.
- SRAM_CE_N  in  1  chip enable, active low.
- SRAM_OE_N  in  1  output enable, active low.
- bd_we  in  1  backdoor write strobe.
- bd_addr  in  ADDR_W  backdoor word address.
- bd_wdata  in  16  backdoor write data.
- bd_rdata  out  16  backdoor read data, combinational array[bd_addr].
- rd_count  out  16  accepted bus reads, saturating.
- wr_count  out  16  accepted bus writes, saturating.
- err_contention  out  1  sticky: write with OE_N asserted.
- err_range  out  1  sticky: access beyond implemented depth.

Behaviour:
- Reset: the array is NOT cleared and keeps its contents across rst. rd_count=0, wr_count=0, err_contention=0, err_range=0. Read pipeline valid bits cleared; DQ=z.
- Access qualifiers, sampled at posedge:
  - WR = !CE_N & !WE_N.
  - RD = !CE_N & WE_N & !OE_N.
  - INRANGE = SRAM_ADDR[17:ADDR_W]==0; always true when ADDR_W=18.
- Write:
  - If WR & INRANGE, array[ADDR][15:8]<=DQ[15:8] when UB_N=0, and array[ADDR][7:0]<=DQ[7:0] when LB_N=0.
  - wr_count increments only if at least one lane is enabled.
  - The device never drives DQ while WE_N=0.
- Read, READ_LAT=0:
  - DQ is driven combinationally while RD & INRANGE, with no clock dependency. Lane [15:8] = array[ADDR][15:8] if UB_N=0, else z; lane [7:0] likewise per LB_N.
  - rd_count increments on each posedge with RD & INRANGE and at least one lane enabled.
- Read, READ_LAT=N>0:
  - At each posedge with RD & INRANGE, a pipeline of N stages captures {valid, data snapshot of array[ADDR], UB_N, LB_N}. The data is read at capture time, so a later write to the same word does not alter in-flight data.
  - The last stage drives DQ per its captured lane masks only while its valid bit is 1 AND current !CE_N & WE_N & !OE_N. Otherwise DQ=z and the entry is dropped silently.
  - rd_count increments at capture.
  - A back-to-back read every cycle yields one word per cycle after N cycles of fill.
- Write/read ordering: a write at posedge k is visible to an asynchronous read from the cycle after k. Bus write and capture in the same cycle cannot occur, since the WE_N qualifiers are exclusive.
- Backdoor:
  - bd_we writes the full word at posedge.
  - If a bus write and a backdoor write hit the same word in the same cycle, the backdoor wins for all lanes.
  - bd_rdata is combinational.
- Errors:
  - err_contention sets at posedge when !CE_N & !WE_N & !OE_N. The write still occurs; DQ is not driven.
  - err_range sets at posedge when (WR|RD) & !INRANGE. The access is ignored: no array change, no count, DQ=z.
  - Both flags stay set until rst.
- Counters saturate at 16'hFFFF and do not wrap.
- rst during a pipelined read: pending entries are discarded and DQ is z from the cycle after the reset posedge. Array writes in the reset cycle are still performed; counters stay 0.
- CE_N=1: all bus inputs are ignored and DQ=z.

Test Plan:
- READ_LAT=0: backdoor array[5]=16'hA1B2, drive ADDR=5, CE_N=0, OE_N=0, WE_N=1, UB_N=LB_N=0 -> DQ=16'hA1B2 in the same cycle. Then UB_N=1 -> DQ=16'hzzB2. rd_count=1 after one posedge.
- Byte write: array[7]=16'h0000, write DQ=16'h1234 with UB_N=0, LB_N=1 -> bd_rdata at addr 7 = 16'h1200, wr_count=1. Repeat with UB_N=LB_N=1 -> no change, wr_count stays 1.
- READ_LAT=2:
  - Words 8..11 = 16'h0008..16'h000B; issue a read burst of 4 consecutive addresses, one per cycle -> DQ shows 16'h0008..16'h000B on cycles 2..5 after the first capture.
  - Writing 16'hFFFF to addr 9 one cycle after its capture still returns 16'h0009.
- Contention and range:
  - WE_N=0, OE_N=0, CE_N=0 -> err_contention=1 next cycle, write performed.
  - With ADDR_W=10, ADDR=18'h00400 -> err_range=1, array unchanged, DQ=z.
  - rst clears both flags.
- Saturation/reset: 65,537 reads -> rd_count=16'hFFFF. Assert rst mid READ_LAT=2 read -> DQ=z the following cycle, counters 0, array contents preserved (backdoor check).

Source files
------------

// File: rtl/sram_device_responder.sv
// Device-side model of the 16-bit asynchronous SRAM bus: word array with byte-lane
// writes, fixed-latency reads on the shared DQ bus, backdoor access, counters and error flags.
module sram_device_responder #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned READ_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [15:0]       SRAM_DQ,
  input  logic [17:0]       SRAM_ADDR,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [15:0]       bd_wdata,
  output logic [15:0]       bd_rdata,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic              err_contention,
  output logic              err_range
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [15:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] waddr;
  logic              wr, rd, inrange, lane_any, wr_acc, rd_acc;

  logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic        err_con_q, err_con_d, err_rng_q, err_rng_d;

  logic        drv_en, drv_ub_n, drv_lb_n;
  logic [15:0] drv_data;

  assign waddr    = SRAM_ADDR[ADDR_W-1:0];
  assign wr       = !SRAM_CE_N && !SRAM_WE_N;
  assign rd       = !SRAM_CE_N &&  SRAM_WE_N && !SRAM_OE_N;
  assign lane_any = !SRAM_UB_N || !SRAM_LB_N;
  assign wr_acc   = wr && inrange && lane_any;
  assign rd_acc   = rd && inrange && lane_any;

  if (ADDR_W < 18) begin : g_range
    assign inrange = (SRAM_ADDR[17:ADDR_W] == '0);
  end else begin : g_full
    assign inrange = 1'b1;
  end

  // Array is deliberately outside reset; backdoor write is last so it wins on a collision.
  always_ff @(posedge clk) begin
    if (wr && inrange) begin
      if (!SRAM_UB_N) mem_q[waddr][15:8] <= SRAM_DQ[15:8];
      if (!SRAM_LB_N) mem_q[waddr][7:0]  <= SRAM_DQ[7:0];
    end
    if (bd_we) mem_q[bd_addr] <= bd_wdata;
  end

  assign bd_rdata = mem_q[bd_addr];

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_acc && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 16'd1;
    if (wr_acc && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 16'd1;
    err_con_d = err_con_q || (wr && !SRAM_OE_N);
    err_rng_d = err_rng_q || ((wr || rd) && !inrange);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_con_q <= 1'b0;
      err_rng_q <= 1'b0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_con_q <= err_con_d;
      err_rng_q <= err_rng_d;
    end
  end

  assign rd_count       = rd_cnt_q;
  assign wr_count       = wr_cnt_q;
  assign err_contention = err_con_q;
  assign err_range      = err_rng_q;

  if (READ_LAT == 0) begin : g_async
    assign drv_en   = rd && inrange;
    assign drv_data = mem_q[waddr];
    assign drv_ub_n = SRAM_UB_N;
    assign drv_lb_n = SRAM_LB_N;
  end else begin : g_pipe
    typedef struct packed {
      logic        vld;
      logic        ub_n;
      logic        lb_n;
      logic [15:0] data;
    } stage_t;

    stage_t [READ_LAT-1:0] pipe_q, pipe_d;

    // Stage 0 snapshots the word at capture; later writes cannot alter in-flight data.
    always_comb begin
      pipe_d    = pipe_q << $bits(stage_t);
      pipe_d[0] = '{vld: rd && inrange, ub_n: SRAM_UB_N, lb_n: SRAM_LB_N, data: mem_q[waddr]};
    end

    always_ff @(posedge clk) begin
      if (rst) pipe_q <= '0;
      else     pipe_q <= pipe_d;
    end

    assign drv_en   = pipe_q[READ_LAT-1].vld && rd;
    assign drv_data = pipe_q[READ_LAT-1].data;
    assign drv_ub_n = pipe_q[READ_LAT-1].ub_n;
    assign drv_lb_n = pipe_q[READ_LAT-1].lb_n;
  end

  assign SRAM_DQ[15:8] = (drv_en && !drv_ub_n) ? drv_data[15:8] : 'z;
  assign SRAM_DQ[7:0]  = (drv_en && !drv_lb_n) ? drv_data[7:0]  : 'z;

endmodule
